// File: rtl/program_counter_pkg.sv
// ----------------------------------------------------------------------------
// program_counter_pkg : core-wide fetch constants and address type  | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package program_counter_pkg;

  localparam int CORE_XLEN         = 64;
  localparam int CORE_PC_INCREMENT = 4;

  typedef logic [CORE_XLEN-1:0] addr_t;

  localparam addr_t CORE_RESET_VECTOR = 64'h0;

  // Sequential fetch address, shared by fetch and the PC+4 link path.
  function automatic addr_t seq_addr(input addr_t pc);
    return pc + addr_t'(CORE_PC_INCREMENT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/program_counter_if.sv
// ----------------------------------------------------------------------------
// program_counter_if : branch decision inputs and fetch PC output   | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface program_counter_if
  import program_counter_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
);

  logic            branch;
  logic            zero;
  logic [XLEN-1:0] immediate;
  logic [XLEN-1:0] pc;

  modport master (
    output branch,
    output zero,
    output immediate,
    input  pc
  );

  modport slave (
    input  branch,
    input  zero,
    input  immediate,
    output pc
  );

endinterface

`default_nettype wire

// File: rtl/program_counter_pc_next_logic.sv
// ----------------------------------------------------------------------------
// pc_next_logic : sequential adder, branch-target adder, taken mux  | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_next_logic
  import program_counter_pkg::*;
#(
  parameter int XLEN         = CORE_XLEN,
  parameter int PC_INCREMENT = CORE_PC_INCREMENT
) (
  input  logic [XLEN-1:0] pc,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] immediate,
  output logic [XLEN-1:0] next_pc
);

  logic            w_taken;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_branch_pc;

  assign w_taken     = branch & zero;
  assign w_seq_pc    = pc + XLEN'(PC_INCREMENT);
  // Immediate is already a sign-extended byte offset; modulo add handles negatives.
  assign w_branch_pc = pc + immediate;
  assign next_pc     = w_taken ? w_branch_pc : w_seq_pc;

endmodule

`default_nettype wire

// File: rtl/program_counter.sv
// ----------------------------------------------------------------------------
// program_counter : RV64 fetch PC register with sync active-low reset | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module program_counter
  import program_counter_pkg::*;
#(
  parameter int              XLEN         = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(CORE_RESET_VECTOR),
  parameter int              PC_INCREMENT = CORE_PC_INCREMENT
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  program_counter_if.slave bus
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;

  pc_next_logic #(
    .XLEN         (XLEN),
    .PC_INCREMENT (PC_INCREMENT)
  ) u_pc_next_logic (
    .pc        (r_pc),
    .branch    (bus.branch),
    .zero      (bus.zero),
    .immediate (bus.immediate),
    .next_pc   (w_next_pc)
  );

  // Reset is tested first so undriven branch inputs cannot leak into the PC.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign bus.pc = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// ----------------------------------------------------------------------------
// tb_program_counter : random + directed bench with behavioural PC model | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_program_counter;
  import program_counter_pkg::*;

  logic  clk;
  logic  rst;
  int    checks;
  int    errors;
  addr_t exp_pc;
  bit    model_valid;

  program_counter_if #(.XLEN(64)) bus ();

  program_counter #(
    .XLEN         (64),
    .RESET_VECTOR (64'h0),
    .PC_INCREMENT (4)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: address arithmetic straight from the fetch rules.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      exp_pc      = 64'h0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (bus.branch === 1'b1 && bus.zero === 1'b1)
        exp_pc = exp_pc + bus.immediate;
      else
        exp_pc = exp_pc + 64'd4;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (bus.pc !== exp_pc) begin
        errors++;
        $display("FAIL model_cmp t=%0t pc=%h expected=%h", $time, bus.pc, exp_pc);
      end
    end
  end

  // Apply one cycle of inputs at a falling edge; check o_PC at the next falling edge.
  task automatic step(input logic r, input logic br, input logic z,
                      input logic [63:0] imm, input bit chk,
                      input logic [63:0] want, input string name);
    rst           = r;
    bus.branch    = br;
    bus.zero      = z;
    bus.immediate = imm;
    @(negedge clk);
    if (chk) begin
      checks++;
      if (bus.pc !== want) begin
        errors++;
        $display("FAIL %s pc=%h expected=%h", name, bus.pc, want);
      end
    end
  endtask

  initial begin
    logic [63:0] imm;
    checks        = 0;
    errors        = 0;
    exp_pc        = '0;
    model_valid   = 1'b0;
    rst           = 1'b0;
    bus.branch    = 1'b0;
    bus.zero      = 1'b0;
    bus.immediate = '0;
    @(negedge clk);

    step(0, 0, 0, 64'd0, 1, 64'd0, "reset_1");
    step(0, 0, 0, 64'd0, 1, 64'd0, "reset_2");
    step(1, 0, 0, 64'd0, 1, 64'd4, "seq_4");
    step(1, 0, 0, 64'd0, 1, 64'd8, "seq_8");
    step(1, 1, 0, 64'd100, 1, 64'd12, "not_taken");
    step(1, 0, 1, 64'd100, 1, 64'd16, "zero_only");
    step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 64'd8, "back_to_8");
    step(1, 1, 1, 64'd16, 1, 64'd24, "taken_fwd");
    step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 64'd16, "taken_back");
    step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFEC, 1, 64'hFFFF_FFFF_FFFF_FFFC, "to_top");
    step(1, 0, 0, 64'd0, 1, 64'd0, "wrap_seq");
    step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'hFFFF_FFFF_FFFF_FFFC, "to_top_2");
    step(1, 1, 1, 64'd8, 1, 64'd4, "wrap_taken");
    step(1, 1, 1, 64'd36, 1, 64'd40, "to_40");
    step(0, 1, 1, 64'd64, 1, 64'd0, "reset_midrun");
    step(1, 0, 0, 64'd0, 1, 64'd4, "release");
    step(1, 1, 1, 64'd16, 1, 64'd20, "to_20");
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 64'd0, 1, 64'd20, "self_loop");
    step(1, 1, 0, 64'd0, 1, 64'd24, "loop_exit");
    step(1, 1, 1, 64'd3, 1, 64'd27, "misaligned");
    step(0, 1'bx, 1'bx, 64'hx, 1, 64'd0, "reset_x");
    step(1, 0, 0, 64'd0, 1, 64'd4, "release_x");

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       imm = {$urandom, $urandom};
        1:       imm = 64'($signed(12'($urandom_range(0, 4095))));
        2:       imm = 64'd0;
        default: imm = {56'h0, 8'($urandom)};
      endcase
      step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom), imm, 0, 64'd0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_counter.md
Name: program_counter

Overview:
- RV64 instruction-fetch program counter for the single-cycle core.
- Holds the address of the current instruction.
- Each clock it advances by 4, or by a signed immediate offset when a conditional branch is taken (branch asserted and ALU zero flag set).
- Output drives the instruction-memory address and the PC-relative adders in the datapath.

Parameters:
- XLEN, 64, width of PC and immediate in bits.
- RESET_VECTOR, 64'h0, PC value loaded on reset.
- PC_INCREMENT, 4, byte step for sequential fetch.

Ports:
- i_Clock  input  1  rising-edge clock; the only clock.
- i_Reset  input  1  reset, synchronous, active-low: 0 = reset, 1 = run.
- i_Branch  input  1  current instruction is a conditional branch (from control unit).
- i_Zero  input  1  ALU zero flag for the branch comparison.
- i_Immediate  input  XLEN  sign-extended byte offset from the immediate generator, two's complement.
- o_PC  output  XLEN  current instruction address, registered.

Behaviour:
- Single XLEN-bit register; o_PC is driven directly from it, with no combinational path from inputs to o_PC.
- All updates occur on the rising edge of i_Clock.
- Reset:
  - i_Reset==0 at a rising edge loads RESET_VECTOR (0).
  - Reset has priority over all other inputs, including X/undriven i_Branch, i_Zero and i_Immediate.
  - Reset is sampled only at clock edges; an asynchronous change of i_Reset has no effect until the next edge.
- Next PC when i_Reset==1:
  - taken = i_Branch & i_Zero.
  - taken=1: PC <= PC + i_Immediate.
  - taken=0: PC <= PC + PC_INCREMENT.
- Latency: the new value is visible on o_PC one cycle after the inputs are sampled. A branch decided in cycle N updates PC at the end of cycle N.
- Arithmetic:
  - Unsigned XLEN-bit addition, modulo 2^XLEN; carry discarded; wrap-around is silent.
  - A negative immediate moves the PC backward by two's-complement addition.
- Immediate is used as-is as a byte offset: no shifting and no alignment masking. Misaligned targets are not detected or trapped at this level.
- i_Branch==1 with i_Zero==0 is a not-taken branch: +4.
- i_Zero is ignored when i_Branch==0.
- Immediate 0 with taken branch: PC holds its value for that cycle (self-loop).
- Reset asserted mid-run: PC returns to RESET_VECTOR at the next edge, regardless of any pending branch.
- First edge after reset release performs a normal update from RESET_VECTOR (0 -> 4 when not taken).
- Power-up before the first reset edge is undefined. The bench must apply reset for at least one edge.
- No stall, enable or exception input; PC advances every non-reset cycle.

Decomposition:
- Shared core package holds:
  - XLEN = 64
  - PC_INCREMENT = 4
  - RESET_VECTOR
  - the XLEN-bit address type used by fetch/decode/ALU.
- One natural sub-module: pc_next_logic.
  - Combinational.
  - Inputs: current PC, i_Branch, i_Zero, i_Immediate.
  - Computes the sequential adder, the branch-target adder and the taken mux; outputs next_pc.
- program_counter keeps only the register and reset mux.

Test Plan:
- Reset low for 2 edges, then high with i_Branch=0, i_Zero=0, i_Immediate=0 -> o_PC = 0 during reset, then 4, 8, 12 on successive edges.
- Not-taken branch: PC=8, i_Branch=1, i_Zero=0, i_Immediate=100 -> next o_PC=12. Zero-only case: i_Branch=0, i_Zero=1 -> also +4.
- Taken forward/backward: PC=8, i_Branch=1, i_Zero=1, i_Immediate=16 -> o_PC=24. Then i_Immediate=-8 (64'hFFFF_FFFF_FFFF_FFF8) -> o_PC=16.
- Wrap-around: force PC to 64'hFFFF_FFFF_FFFF_FFFC via taken branch, then not-taken -> o_PC=0. Taken with i_Immediate=8 from that value -> o_PC=4.
- Reset mid-run with taken branch pending: PC=40, i_Reset=0, i_Branch=1, i_Zero=1, i_Immediate=64 -> o_PC=0. Release -> 4.
- Self-loop: taken with i_Immediate=0 at PC=20 held for 3 cycles -> o_PC stays 20. Deassert i_Zero -> 24.
